// File: rtl/ads_frame_reader.sv
// Serial frame capture for ADS167x-class ADCs (daisy-chain capable): START strobe,
// divided sclk, DRDY wait with timeout, MSB-first shift and valid/ready frame output.
module ads_frame_reader #(
    parameter int DATA_WIDTH  = 24,
    parameter int NUM_CH      = 1,
    parameter int SCLK_DIV    = 2,
    parameter int START_CYC   = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         trigger,
    input  logic                         cont,
    input  logic                         stop,
    input  logic                         drdy_n,
    input  logic                         drr,
    output logic                         start,
    output logic                         sclk,
    output logic [NUM_CH*DATA_WIDTH-1:0] frame_data,
    output logic                         frame_valid,
    input  logic                         frame_ready,
    output logic                         busy,
    output logic                         timeout,
    output logic                         overrun
);

    localparam int FRAME_W = NUM_CH * DATA_WIDTH;
    localparam int CNT_MAX = (TIMEOUT_CYC > START_CYC) ? TIMEOUT_CYC : START_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int DIV_W   = $clog2(SCLK_DIV + 1);
    localparam int BIT_W   = $clog2(FRAME_W + 1);

    localparam logic [CNT_W-1:0] START_LAST   = CNT_W'(START_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(SCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST     = BIT_W'(FRAME_W - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]         state;
    logic               mode;
    logic               stop_seen;
    logic [CNT_W-1:0]   cyc_cnt;
    logic [DIV_W-1:0]   div_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [FRAME_W-1:0] shreg;
    logic               drdy_n_p0, drdy_n_p1, drdy_n_p2;
    logic               drr_p0, drr_p1;
    logic               drdy_evt;
    logic               sample_now;

    // Stage p0/p1: two-flop synchronisers; p2 holds the previous drdy_n for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            drdy_n_p0 <= 1'b1;
            drdy_n_p1 <= 1'b1;
            drdy_n_p2 <= 1'b1;
        end else begin
            drdy_n_p0 <= drdy_n;
            drdy_n_p1 <= drdy_n_p0;
            drdy_n_p2 <= drdy_n_p1;
        end
    end

    always_ff @(posedge clk) begin
        drr_p0 <= drr;
        drr_p1 <= drr_p0;
    end

    assign drdy_evt   = drdy_n_p2 & ~drdy_n_p1;
    assign sample_now = (state == S_SHIFT) && (div_cnt == DIV_LAST) && !sclk;

    always_ff @(posedge clk) begin
        if (sample_now) shreg <= {shreg[FRAME_W-2:0], drr_p1};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            mode        <= 1'b0;
            stop_seen   <= 1'b0;
            cyc_cnt     <= '0;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            sclk        <= 1'b0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            timeout     <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            timeout <= 1'b0;
            overrun <= 1'b0;
            if (frame_valid && frame_ready) frame_valid <= 1'b0;
            if (stop && state != S_IDLE) stop_seen <= 1'b1;

            case (state)
                S_IDLE: begin
                    stop_seen <= 1'b0;
                    cyc_cnt   <= '0;
                    if (trigger) begin
                        mode  <= cont;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (cyc_cnt == START_LAST) begin
                        cyc_cnt <= '0;
                        state   <= S_WAIT;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    // DRDY is checked first so it wins a tie with the timeout
                    if (drdy_evt) begin
                        cyc_cnt <= '0;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        sclk    <= 1'b0;
                        state   <= S_SHIFT;
                    end else if (cyc_cnt == TIMEOUT_LAST) begin
                        cyc_cnt <= '0;
                        timeout <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        sclk    <= ~sclk;
                        if (sclk) begin
                            if (bit_cnt == BIT_LAST) state <= S_DONE;
                            else bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    // A pending unconsumed frame is kept; the new one is dropped
                    if (frame_valid && !frame_ready) begin
                        overrun <= 1'b1;
                    end else begin
                        frame_data  <= shreg;
                        frame_valid <= 1'b1;
                    end
                    state <= (mode && !stop_seen && !stop) ? S_WAIT : S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy  = (state != S_IDLE);
    assign start = (state == S_START) | (mode & busy);

endmodule
